// File: rtl/piso_if.sv
// Load handshake and serial-output bundle for piso_serializer.
// master = word producer / bit consumer, slave = serializer.
interface piso_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pi;
    logic             shift_en;
    logic             so;
    logic             so_valid;
    logic             so_last;
    logic             busy;

    modport master (
        output load_valid, pi, shift_en,
        input  load_ready, so, so_valid, so_last, busy
    );

    modport slave (
        input  load_valid, pi, shift_en,
        output load_ready, so, so_valid, so_last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: WIDTH-bit word in via valid/ready,
// one bit out per enabled clock, MSB- or LSB-first, gapless back-to-back frames.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic clk,
    input  logic rst,
    piso_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg, sreg_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             so_q, so_nx;
    logic             last_q, last_nx;
    logic             load_ready_c;
    logic             load_acc;
    logic             consume;

    // State register; reset wins over load and shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            so_q   <= 1'b0;
            last_q <= 1'b0;
        end else begin
            state  <= state_nx;
            sreg   <= sreg_nx;
            cnt    <= cnt_nx;
            so_q   <= so_nx;
            last_q <= last_nx;
        end
    end

    // Next-state: a load on the last-bit edge takes priority, keeping the stream gapless.
    always_comb begin
        state_nx     = state;
        sreg_nx      = sreg;
        cnt_nx       = cnt;
        so_nx        = so_q;
        load_ready_c = (cnt == '0) || ((cnt == CW'(1)) && bus.shift_en);
        load_acc     = bus.load_valid && load_ready_c;
        consume      = (state == SHIFT) && bus.shift_en;

        if (load_acc) begin
            state_nx = SHIFT;
            sreg_nx  = bus.pi;
            cnt_nx   = CW'(WIDTH);
            so_nx    = LSB_FIRST ? bus.pi[0] : bus.pi[WIDTH-1];
        end else if (consume) begin
            cnt_nx  = cnt - CW'(1);
            sreg_nx = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
            so_nx   = LSB_FIRST ? sreg_nx[0] : sreg_nx[WIDTH-1];
            if (cnt == CW'(1)) begin
                state_nx = IDLE;
                so_nx    = 1'b0;
            end
        end

        // Registered copy of so_valid & (cnt == 1), computed from next values.
        last_nx = (state_nx == SHIFT) && (cnt_nx == CW'(1));
    end

    assign bus.load_ready = load_ready_c;
    assign bus.so         = so_q;
    assign bus.so_valid   = (state == SHIFT);
    assign bus.busy       = (state == SHIFT);
    assign bus.so_last    = last_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances (8/MSB, 8/LSB, 4/MSB)
// driven from a vector table plus hand-written multi-cycle sequences.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piso_if #(.WIDTH(8)) if0 ();
    piso_if #(.WIDTH(8)) if1 ();
    piso_if #(.WIDTH(4)) if2 ();

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    typedef struct packed {
        logic [1:0] sel;
        logic       rst;
        logic       lv;
        logic [7:0] pi;
        logic       se;
        logic       so;
        logic       vld;
        logic       last;
        logic       rdy;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] sel, input logic r, input logic lv,
                                input logic [7:0] p, input logic se, input logic so,
                                input logic vld, input logic last, input logic rdy);
        vec_t v;
        v.sel = sel; v.rst = r; v.lv = lv; v.pi = p; v.se = se;
        v.so = so; v.vld = vld; v.last = last; v.rdy = rdy;
        return v;
    endfunction

    // Load row (block seen idle) followed by n shifting rows; seq lists bits in emission order, left first.
    function automatic void add_frame(input logic [1:0] sel, input int n,
                                      input logic [7:0] word, input logic [7:0] seq);
        tbl.push_back(mk(sel, 1'b0, 1'b1, word, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < n; i++)
            tbl.push_back(mk(sel, 1'b0, 1'b0, 8'h00, 1'b1, seq[n-1-i], 1'b1,
                             (i == n-1), (i == n-1)));
    endfunction

    task automatic chk(input string name, input string fld, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d %s: got %b expected %b", name, cyc, fld, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        logic a_so, a_vld, a_last, a_rdy, a_busy;
        @(negedge clk);
        cyc++;
        rst            = v.rst;
        if0.load_valid = (v.sel == 2'd0) && v.lv;
        if1.load_valid = (v.sel == 2'd1) && v.lv;
        if2.load_valid = (v.sel == 2'd2) && v.lv;
        if0.shift_en   = (v.sel == 2'd0) && v.se;
        if1.shift_en   = (v.sel == 2'd1) && v.se;
        if2.shift_en   = (v.sel == 2'd2) && v.se;
        if0.pi         = v.pi;
        if1.pi         = v.pi;
        if2.pi         = v.pi[3:0];
        #1;
        case (v.sel)
            2'd0:    begin a_so = if0.so; a_vld = if0.so_valid; a_last = if0.so_last;
                           a_rdy = if0.load_ready; a_busy = if0.busy; end
            2'd1:    begin a_so = if1.so; a_vld = if1.so_valid; a_last = if1.so_last;
                           a_rdy = if1.load_ready; a_busy = if1.busy; end
            default: begin a_so = if2.so; a_vld = if2.so_valid; a_last = if2.so_last;
                           a_rdy = if2.load_ready; a_busy = if2.busy; end
        endcase
        chk(name, "so", a_so, v.so);
        chk(name, "so_valid", a_vld, v.vld);
        chk(name, "so_last", a_last, v.last);
        chk(name, "load_ready", a_rdy, v.rdy);
        chk(name, "busy", a_busy, v.vld);
    endtask

    initial begin
        logic [10:0] st_se, st_so;
        logic [15:0] b2b;
        logic [7:0]  b4;

        if0.load_valid = 1'b0; if0.shift_en = 1'b0; if0.pi = '0;
        if1.load_valid = 1'b0; if1.shift_en = 1'b0; if1.pi = '0;
        if2.load_valid = 1'b0; if2.shift_en = 1'b0; if2.pi = '0;

        // Table: reset values on every instance, then the basic frames.
        for (int s = 0; s < 3; s++)
            tbl.push_back(mk(2'(s), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        add_frame(2'd0, 8, 8'hB4, 8'b10110100);
        add_frame(2'd1, 8, 8'hB4, 8'b00101101);
        add_frame(2'd2, 4, 8'h05, 8'b00000101);
        add_frame(2'd2, 4, 8'h0B, 8'b00001011);
        tbl.push_back(mk(2'd2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], "table");

        // Stall: shift_en low for 3 cycles while the 2nd bit is shown.
        st_se = 11'b10001111111;
        st_so = 11'b10000110100;
        step(mk(2'd0, 1'b0, 1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "stall_load");
        for (int i = 0; i < 11; i++)
            step(mk(2'd0, 1'b0, 1'b0, 8'h00, st_se[10-i], st_so[10-i], 1'b1,
                    (i == 10), (i == 10)), "stall");
        step(mk(2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "stall_idle");

        // Back-to-back: 8'h3C offered on the so_last cycle of 8'hB4.
        b2b = 16'b1011010000111100;
        step(mk(2'd0, 1'b0, 1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "b2b_load");
        for (int i = 0; i < 16; i++)
            step(mk(2'd0, 1'b0, (i == 7), (i == 7) ? 8'h3C : 8'h00, 1'b1, b2b[15-i], 1'b1,
                    (i == 7) || (i == 15), (i == 7) || (i == 15)), "b2b");
        step(mk(2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "b2b_idle");

        // Load while busy: 8'hFF offered during bit 3 is refused.
        b4 = 8'b10110100;
        step(mk(2'd0, 1'b0, 1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "busy_load");
        for (int i = 0; i < 8; i++)
            step(mk(2'd0, 1'b0, (i == 2), (i == 2) ? 8'hFF : 8'h00, 1'b1, b4[7-i], 1'b1,
                    (i == 7), (i == 7)), "busy");
        step(mk(2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "busy_idle");

        // Reset after bit 4, with a load offered in the reset cycle that must be dropped.
        step(mk(2'd0, 1'b0, 1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "rst_load");
        for (int i = 0; i < 4; i++)
            step(mk(2'd0, 1'b0, 1'b0, 8'h00, 1'b1, b4[7-i], 1'b1, 1'b0, 1'b0), "rst_pre");
        step(mk(2'd0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), "rst_cycle");
        step(mk(2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "rst_after");
        step(mk(2'd0, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "rst_reload");
        b4 = 8'b10000001;
        for (int i = 0; i < 8; i++)
            step(mk(2'd0, 1'b0, 1'b0, 8'h00, 1'b1, b4[7-i], 1'b1, (i == 7), (i == 7)), "rst_81");
        step(mk(2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "rst_81_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
